// File: rtl/regfile_scoreboard_if.sv
// Register file bus: two read ports, one write port, one reserve port.
// master = issue/writeback side, slave = register file.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   regAddrA;
  logic                regReA;
  logic [DATA_W-1:0]   busA;
  logic                regPendA;
  logic [ADDR_W-1:0]   regAddrB;
  logic                regReB;
  logic [DATA_W-1:0]   busB;
  logic                regPendB;
  logic [ADDR_W-1:0]   regAddrD;
  logic                regWeD;
  logic [DATA_W/8-1:0] regBeD;
  logic [DATA_W-1:0]   busD;
  logic                regRsvD;
  logic [ADDR_W-1:0]   regAddrR;

  modport master (
    output regAddrA, regReA,
    output regAddrB, regReB,
    output regAddrD, regWeD, regBeD, busD,
    output regRsvD, regAddrR,
    input  busA, regPendA,
    input  busB, regPendB
  );

  modport slave (
    input  regAddrA, regReA,
    input  regAddrB, regReB,
    input  regAddrD, regWeD, regBeD, busD,
    input  regRsvD, regAddrR,
    output busA, regPendA,
    output busB, regPendB
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2R/1W register file, registered reads, byte enables, pending scoreboard.
// Ports: clk, rst (sync, active high), rf (regfile_scoreboard_if.slave).
// Optional macro REGS_BYPASS_EN: same-edge write/reserve forwarded to reads.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_scoreboard_if.slave   rf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic              zero_d;
  logic              zero_r;
  logic              zero_a;
  logic              zero_b;
  logic              we_ok;
  logic              rsv_ok;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              pd_a;
  logic              pd_b;

  assign zero_d = (ZERO_REG != 0) && (rf.regAddrD == '0);
  assign zero_r = (ZERO_REG != 0) && (rf.regAddrR == '0);
  assign zero_a = (ZERO_REG != 0) && (rf.regAddrA == '0);
  assign zero_b = (ZERO_REG != 0) && (rf.regAddrB == '0);

  assign we_ok  = rf.regWeD && !zero_d;
  assign rsv_ok = rf.regRsvD && !zero_r;

  // Byte-merge new data over the current register contents.
  always_comb begin
    wr_data = mem[rf.regAddrD];
    for (int i = 0; i < NB; i++) begin
      if (rf.regBeD[i]) begin
        wr_data[i*8 +: 8] = rf.busD[i*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_a = mem[rf.regAddrA];
    rd_b = mem[rf.regAddrB];
    pd_a = pend[rf.regAddrA];
    pd_b = pend[rf.regAddrB];
`ifdef REGS_BYPASS_EN
    // Forward the post-edge state; reserve beats write on pending.
    if (we_ok && rf.regAddrD == rf.regAddrA) begin
      rd_a = wr_data;
      pd_a = 1'b0;
    end
    if (we_ok && rf.regAddrD == rf.regAddrB) begin
      rd_b = wr_data;
      pd_b = 1'b0;
    end
    if (rsv_ok && rf.regAddrR == rf.regAddrA) begin
      pd_a = 1'b1;
    end
    if (rsv_ok && rf.regAddrR == rf.regAddrB) begin
      pd_b = 1'b1;
    end
`endif
    if (zero_a) begin
      rd_a = '0;
      pd_a = 1'b0;
    end
    if (zero_b) begin
      rd_b = '0;
      pd_b = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      pend        <= '0;
      rf.busA     <= '0;
      rf.busB     <= '0;
      rf.regPendA <= 1'b0;
      rf.regPendB <= 1'b0;
    end else begin
      if (we_ok) begin
        mem[rf.regAddrD]  <= wr_data;
        pend[rf.regAddrD] <= 1'b0;
      end
      // Later assignment: a new producer overrides the completing one.
      if (rsv_ok) begin
        pend[rf.regAddrR] <= 1'b1;
      end
      if (rf.regReA) begin
        rf.busA     <= rd_a;
        rf.regPendA <= pd_a;
      end
      if (rf.regReB) begin
        rf.busB     <= rd_b;
        rf.regPendB <= pd_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
// Default parameters: DATA_W=16, ADDR_W=5, ZERO_REG=1.
module tb_regfile_scoreboard;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(5)) rf ();

  regfile_scoreboard #(
    .DATA_W  (16),
    .ADDR_W  (5),
    .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rf (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rf.regAddrA = '0;
    rf.regReA   = 1'b0;
    rf.regAddrB = '0;
    rf.regReB   = 1'b0;
    rf.regAddrD = '0;
    rf.regWeD   = 1'b0;
    rf.regBeD   = '0;
    rf.busD     = '0;
    rf.regRsvD  = 1'b0;
    rf.regAddrR = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [15:0] d,
                    input logic [1:0] be);
    rf.regAddrD = a;
    rf.regWeD   = 1'b1;
    rf.busD     = d;
    rf.regBeD   = be;
  endtask

  task automatic rd_a(input logic [4:0] a);
    rf.regAddrA = a;
    rf.regReA   = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b1;
    step();
    check("rst_busA", 32'(rf.busA), 32'h0);
    check("rst_busB", 32'(rf.busB), 32'h0);
    check("rst_pendA", 32'(rf.regPendA), 32'h0);
    check("rst_pendB", 32'(rf.regPendB), 32'h0);
    rst = 1'b0;

    // reset clears written data
    wr(5'd3, 16'h1234, 2'b11);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_a(5'd3);
    step();
    check("rst_r3_data", 32'(rf.busA), 32'h0);
    check("rst_r3_pend", 32'(rf.regPendA), 32'h0);
    idle();

    // full write, dual read
    wr(5'd5, 16'hBEEF, 2'b11);
    step();
    idle();
    rd_a(5'd5);
    rf.regAddrB = 5'd5;
    rf.regReB   = 1'b1;
    step();
    check("r5_busA", 32'(rf.busA), 32'hBEEF);
    check("r5_busB", 32'(rf.busB), 32'hBEEF);
    idle();

    // low byte only
    wr(5'd5, 16'h00AA, 2'b01);
    step();
    idle();
    rd_a(5'd5);
    step();
    check("r5_byte", 32'(rf.busA), 32'hBEAA);
    idle();

    // zero register ignores write and reserve
    wr(5'd0, 16'hFFFF, 2'b11);
    rf.regRsvD  = 1'b1;
    rf.regAddrR = 5'd0;
    step();
    idle();
    rd_a(5'd0);
    step();
    check("r0_data", 32'(rf.busA), 32'h0);
    check("r0_pend", 32'(rf.regPendA), 32'h0);
    idle();

    // scoreboard
    rf.regRsvD  = 1'b1;
    rf.regAddrR = 5'd7;
    step();
    idle();
    rd_a(5'd7);
    step();
    check("r7_rsv_pend", 32'(rf.regPendA), 32'h1);
    idle();
    wr(5'd7, 16'h0042, 2'b11);
    rf.regRsvD  = 1'b1;
    rf.regAddrR = 5'd7;
    step();
    idle();
    rd_a(5'd7);
    step();
    check("r7_both_pend", 32'(rf.regPendA), 32'h1);
    check("r7_both_data", 32'(rf.busA), 32'h0042);
    idle();
    wr(5'd7, 16'h0042, 2'b00);
    step();
    idle();
    rd_a(5'd7);
    step();
    check("r7_clr_pend", 32'(rf.regPendA), 32'h0);
    check("r7_be0_data", 32'(rf.busA), 32'h0042);
    idle();

    // collision
    wr(5'd9, 16'h1111, 2'b11);
    step();
    idle();
    wr(5'd9, 16'h5555, 2'b11);
    rd_a(5'd9);
    step();
`ifdef REGS_BYPASS_EN
    check("r9_coll", 32'(rf.busA), 32'h5555);
`else
    check("r9_coll", 32'(rf.busA), 32'h1111);
`endif
    idle();
    rd_a(5'd9);
    step();
    check("r9_after", 32'(rf.busA), 32'h5555);
    idle();

    // collision with reserve: pending forwarding
    wr(5'd9, 16'h5555, 2'b00);
    rf.regRsvD  = 1'b1;
    rf.regAddrR = 5'd9;
    rd_a(5'd9);
    step();
`ifdef REGS_BYPASS_EN
    check("r9_coll_pend", 32'(rf.regPendA), 32'h1);
`else
    check("r9_coll_pend", 32'(rf.regPendA), 32'h0);
`endif
    idle();
    rd_a(5'd9);
    step();
    check("r9_pend_after", 32'(rf.regPendA), 32'h1);
    check("r9_be0_data", 32'(rf.busA), 32'h5555);
    idle();

    // hold and reset over an in-flight write
    rd_a(5'd5);
    step();
    check("r5_read", 32'(rf.busA), 32'hBEAA);
    idle();
    wr(5'd5, 16'h0001, 2'b11);
    step();
    check("r5_hold", 32'(rf.busA), 32'hBEAA);
    idle();
    wr(5'd5, 16'hFFFF, 2'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("rst_mid_busA", 32'(rf.busA), 32'h0);
    rd_a(5'd5);
    step();
    check("rst_mid_r5", 32'(rf.busA), 32'h0);
    idle();
    rd_a(5'd9);
    step();
    check("rst_mid_r9pend", 32'(rf.regPendA), 32'h0);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the combinational 3-port register file.
- Synchronous 2-read / 1-write register file with registered read data and per-byte write enables.
- Adds a per-register pending (scoreboard) bit so the issue logic can detect RAW hazards on in-flight results.
- Sits between the decode/issue stage (reads A/B, reserve) and writeback (port D).

Parameters:
DATA_W, 16, register and bus width in bits; must be a multiple of 8
ADDR_W, 5, address width; depth = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes and reserves ignored); 0 = register 0 is ordinary

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
regAddrA  in  ADDR_W  read port A address
regReA  in  1  read port A enable
busA  out  DATA_W  read port A data, registered
regPendA  out  1  pending bit of the register read on A, registered
regAddrB  in  ADDR_W  read port B address
regReB  in  1  read port B enable
busB  out  DATA_W  read port B data, registered
regPendB  out  1  pending bit of the register read on B, registered
regAddrD  in  ADDR_W  write address
regWeD  in  1  write enable
regBeD  in  DATA_W/8  byte enables; bit i covers busD[8i+7:8i]
busD  in  DATA_W  write data
regRsvD  in  1  reserve strobe: mark regAddrR pending
regAddrR  in  ADDR_W  reserve address

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - all registers 0; all pending bits 0.
  - busA, busB, regPendA, regPendB = 0.
  - rst overrides every other input in that cycle, including a write or reserve already in flight.
- Read latency is 1 cycle:
  - When regReX=1 at edge N, busX and regPendX show the register contents and pending bit after edge N.
  - When regReX=0, busX and regPendX hold their previous values.
- Write:
  - When regWeD=1 at an edge, each byte of register regAddrD with regBeD[i]=1 takes busD's byte; bytes with regBeD[i]=0 are unchanged.
  - regBeD all zero changes no data.
- Pending bits:
  - regRsvD=1 sets pending[regAddrR].
  - regWeD=1 clears pending[regAddrD], regardless of regBeD.
  - Reserve and write to the same address in the same cycle: reserve wins, bit ends set (a new producer was issued).
  - Reserve of an already-pending register: stays set, no error.
- Zero register (ZERO_REG=1):
  - Reads of address 0 return data 0 and pending 0 (port A and B).
  - Writes and reserves to address 0 have no effect.
- Same-cycle read/write collision without the optional feature:
  - The read returns the pre-edge data and pre-edge pending bit.
- Both read ports may read the same address in the same cycle; each returns identical data.
- No combinational path from any input to any output.

Optional Feature:
- Macro: REGS_BYPASS_EN.
- Defined:
  - A read at the same edge as a write to the same non-zero address returns the post-write value, byte-merged per regBeD.
  - Pending likewise returns the post-update value, applying the reserve-wins rule.
  - Read-after-write costs 0 extra cycles.
- Undefined:
  - Collision returns the old data and old pending bit.
  - Issue logic must stall one cycle.

Test Plan:
- Reset: write 0x1234 to r3, assert rst one cycle, read r3 on A -> busA=0x0000, regPendA=0 after the read edge.
- Write r5=0xBEEF with regBeD=2'b11, next cycle read r5 on A and B -> busA=busB=0xBEEF, one cycle after regRe. Then write 0x00AA with regBeD=2'b01 -> read returns 0xBEAA.
- Zero register, ZERO_REG=1: write r0=0xFFFF and reserve r0, read r0 on A -> busA=0, regPendA=0.
- Scoreboard:
  - Reserve r7, read r7 -> regPendA=1.
  - Write r7=0x0042 while reserving r7 in the same cycle, read -> regPendA=1, busA=0x0042.
  - Write r7 again with no reserve, read -> regPendA=0.
- Collision: write r9=0x5555 (r9 previously 0x1111) while reading r9 on A in the same cycle.
  - Without REGS_BYPASS_EN -> busA=0x1111; the next read gives 0x5555.
  - With REGS_BYPASS_EN -> busA=0x5555 immediately.
- Hold/reset mid-operation: read r5 (busA=0xBEAA), deassert regReA and write r5=0x0001 -> busA stays 0xBEAA. Then assert rst together with regWeD to r5 -> r5 reads 0 afterwards.
